// File: rtl/intc_multi.sv
// Multi-source interrupt controller: synchronised inputs, per-source mask and edge/level mode,
// pending register and fixed-priority claim with a one-cycle ack pulse back to the source.
module intc_multi #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_WIDTH    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  src_req,
  output logic [NUM_SRC-1:0]  src_ack,
  input  logic                reg_sel,
  input  logic                reg_is_write,
  input  logic [1:0]          reg_addr,
  input  logic [31:0]         reg_data_in,
  output logic [31:0]         reg_data_out,
  output logic                irq,
  output logic [ID_WIDTH-1:0] irq_id
);

  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrMode    = 2'd2;
  localparam logic [1:0] AddrClaim   = 2'd3;

  logic [NUM_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]  edge_q;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [NUM_SRC-1:0]  mode_q, mode_d;
  logic [NUM_SRC-1:0]  ack_d;
  logic [ID_WIDTH-1:0] id_d;
  logic                irq_d;
  logic [31:0]         rdata_d;

  logic [NUM_SRC-1:0] sync_lvl, rise, active, wdata, w1c, claim_vec;
  logic               wr_en, rd_en, claim;

  if (NUM_SRC < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^reg_data_in[31:NUM_SRC];
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~edge_q;
  assign active   = pending_q & mask_q;
  assign wdata    = reg_data_in[NUM_SRC-1:0];
  assign wr_en    = reg_sel & reg_is_write;
  assign rd_en    = reg_sel & ~reg_is_write;
  assign claim    = rd_en && (reg_addr == AddrClaim) && (irq_id != '0);
  assign w1c      = (wr_en && reg_addr == AddrPending) ? wdata : '0;

  always_comb begin
    claim_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_id == ID_WIDTH'(i + 1)) claim_vec[i] = claim;
    end
  end
  assign ack_d = claim_vec;

  // Edge bits: a new rising edge wins over W1C/claim clears in the same cycle.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = (pending_q[i] & ~(w1c[i] | claim_vec[i])) | rise[i];
      end else begin
        pending_d[i] = sync_lvl[i];
      end
      if (wr_en && reg_addr == AddrMode && wdata[i] && !mode_q[i]) pending_d[i] = 1'b0;
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && reg_addr == AddrMask) mask_d = wdata;
    if (wr_en && reg_addr == AddrMode) mode_d = wdata;
  end

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    id_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_d = ID_WIDTH'(i + 1);
    end
    irq_d = |active;
  end

  always_comb begin
    rdata_d = reg_data_out;
    if (rd_en) begin
      rdata_d = '0;
      unique case (reg_addr)
        AddrPending: rdata_d[NUM_SRC-1:0] = pending_q;
        AddrMask:    rdata_d[NUM_SRC-1:0] = mask_q;
        AddrMode:    rdata_d[NUM_SRC-1:0] = mode_q;
        AddrClaim:   rdata_d[ID_WIDTH-1:0] = irq_id;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      edge_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      src_ack      <= '0;
      irq          <= 1'b0;
      irq_id       <= '0;
      reg_data_out <= '0;
    end else begin
      sync_q[0] <= src_req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q       <= sync_lvl;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      src_ack      <= ack_d;
      irq          <= irq_d;
      irq_id       <= id_d;
      reg_data_out <= rdata_d;
    end
  end

endmodule
